// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF    = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_VALID
  } fetch_state_e;

  typedef enum logic [1:0] {
    RDR_NONE,
    RDR_BRANCH,
    RDR_TRAP
  } redir_src_e;

  typedef struct packed {
    redir_src_e      src;
    logic [XLEN-1:0] target;
  } redir_t;

  // Fetch addresses are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction memory request/grant and response channel.
interface fetch_ctrl_if;

  logic                       imem_req;
  logic [fetch_pkg::XLEN-1:0] imem_addr;
  logic                       imem_gnt;
  logic                       imem_rvalid;
  logic [fetch_pkg::XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_redirect_latch.sv
// Selects the active redirect (trap over branch) and holds one raised while
// a memory response is still outstanding.
module fetch_redirect_latch
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_tgt_i,
  input  logic            latch_i,
  input  logic            clear_i,
  output logic            sample_c,
  output logic [XLEN-1:0] sample_tgt_c,
  output redir_t          merged_c
);

  redir_t pend_q, pend_d;

  assign sample_c     = trap_i | branch_i;
  assign sample_tgt_c = trap_i ? trap_vec_i : branch_tgt_i;

  // A new trap always wins; a new branch never displaces a pending trap.
  always_comb begin
    merged_c = pend_q;
    if (trap_i) begin
      merged_c = '{src: RDR_TRAP, target: trap_vec_i};
    end else if (branch_i && (pend_q.src != RDR_TRAP)) begin
      merged_c = '{src: RDR_BRANCH, target: branch_tgt_i};
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (clear_i) begin
      pend_d = '{src: RDR_NONE, target: '0};
    end else if (latch_i) begin
      pend_d = merged_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '{src: RDR_NONE, target: '0};
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage controller: sequences one instruction memory access at a time,
// buffers the response for decode and steers the PC on advance or redirect.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR    = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_Next,
  output logic            StallF,
  input  logic            StallD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            TrapReq,
  input  logic [XLEN-1:0] TrapVector,
  fetch_ctrl_if.master    imem,
  output logic [XLEN-1:0] InstrF,
  output logic            InstrValidF,
  output logic            FlushD
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] buf_q, buf_d;

  logic            redir_c;
  logic [XLEN-1:0] redir_tgt_c;
  redir_t          merged_c;
  logic            latch_c, clear_c;
  logic            req_c, stall_c, valid_c, flush_c;
  logic [XLEN-1:0] pc_next_c;

  fetch_redirect_latch u_redirect (
    .clk          (clk),
    .rst_n        (rst),
    .trap_i       (TrapReq),
    .trap_vec_i   (TrapVector),
    .branch_i     (PCSrcE),
    .branch_tgt_i (PCTargetE),
    .latch_i      (latch_c),
    .clear_i      (clear_c),
    .sample_c     (redir_c),
    .sample_tgt_c (redir_tgt_c),
    .merged_c     (merged_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      buf_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    req_c     = 1'b0;
    stall_c   = 1'b1;
    valid_c   = 1'b0;
    flush_c   = redir_c;
    pc_next_c = PC;
    latch_c   = 1'b0;
    clear_c   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
        if (redir_c) begin
          stall_c   = 1'b0;
          pc_next_c = redir_tgt_c;
        end
      end

      ST_REQ: begin
        req_c = 1'b1;
        if (redir_c) begin
          stall_c   = 1'b0;
          pc_next_c = redir_tgt_c;
        end else if (imem.imem_gnt) begin
          state_d = ST_WAIT;
        end
      end

      // A response that races or follows a redirect belongs to the dead path.
      ST_WAIT: begin
        if (imem.imem_rvalid) begin
          if (merged_c.src != RDR_NONE) begin
            stall_c   = 1'b0;
            pc_next_c = merged_c.target;
            clear_c   = 1'b1;
            state_d   = ST_REQ;
          end else begin
            buf_d   = imem.imem_rdata;
            state_d = ST_VALID;
          end
        end else if (redir_c) begin
          latch_c = 1'b1;
        end
      end

      ST_VALID: begin
        valid_c = 1'b1;
        if (redir_c) begin
          stall_c   = 1'b0;
          pc_next_c = redir_tgt_c;
          buf_d     = NOP_INSTR;
          state_d   = ST_REQ;
        end else if (!StallD) begin
          stall_c   = 1'b0;
          pc_next_c = PC + XLEN'(4);
          buf_d     = NOP_INSTR;
          state_d   = ST_REQ;
        end
      end

      default: state_d = ST_BOOT;
    endcase

    // Outputs show their quiescent values for as long as reset is held.
    if (!rst) begin
      req_c     = 1'b0;
      stall_c   = 1'b1;
      valid_c   = 1'b0;
      flush_c   = 1'b0;
      pc_next_c = RESET_VECTOR;
      latch_c   = 1'b0;
      clear_c   = 1'b0;
    end
  end

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = PC;
  assign PC_Next        = word_align(pc_next_c);
  assign StallF         = stall_c;
  assign InstrValidF    = valid_c;
  assign InstrF         = valid_c ? buf_q : NOP_INSTR;
  assign FlushD         = flush_c;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_ctrl;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic [31:0] PC_Next;
  logic        StallF;
  logic        StallD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        TrapReq;
  logic [31:0] TrapVector;
  logic [31:0] InstrF;
  logic        InstrValidF;
  logic        FlushD;

  fetch_ctrl_if imem_bus ();

  fetch_ctrl #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .PC          (PC),
    .PC_Next     (PC_Next),
    .StallF      (StallF),
    .StallD      (StallD),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .TrapReq     (TrapReq),
    .TrapVector  (TrapVector),
    .imem        (imem_bus),
    .InstrF      (InstrF),
    .InstrValidF (InstrValidF),
    .FlushD      (FlushD)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch stage currently owes the pipeline.
  bit          m_boot = 1'b1;
  bit          m_out  = 1'b0;
  logic [31:0] m_held[$];
  bit          m_pv    = 1'b0;
  bit          m_ptrap = 1'b0;
  logic [31:0] m_ptgt  = '0;
  logic [31:0] exp_next  = RV;
  logic        exp_stall = 1'b1;

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // The bench owns the PC register, loaded from the model's expectations.
  logic [31:0] pc_reg = RV;
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_reg <= RV;
    else if (!exp_stall) pc_reg <= exp_next;
  end
  assign PC = pc_reg;

  always @(negedge clk) begin : compare
    logic        rd, st, vl, fl, rq, mv, mtrap;
    logic [31:0] tgt, nxt, ins, mt;
    rd  = TrapReq || PCSrcE;
    tgt = align(TrapReq ? TrapVector : PCTargetE);
    nxt = align(PC);
    st = 1'b1; vl = 1'b0; fl = 1'b0; rq = 1'b0; ins = NOP;
    if (!rst) begin
      nxt = RV;
      m_boot = 1'b1; m_out = 1'b0; m_held.delete(); m_pv = 1'b0;
    end else begin
      fl = rd;
      if (m_boot) begin
        m_boot = 1'b0;
        if (rd) begin st = 1'b0; nxt = tgt; end
      end else if (m_out) begin
        mv = m_pv; mtrap = m_ptrap; mt = m_ptgt;
        if (TrapReq) begin mv = 1'b1; mtrap = 1'b1; mt = TrapVector; end
        else if (PCSrcE && !(m_pv && m_ptrap)) begin mv = 1'b1; mtrap = 1'b0; mt = PCTargetE; end
        if (imem_bus.imem_rvalid) begin
          m_out = 1'b0;
          if (mv) begin st = 1'b0; nxt = align(mt); m_pv = 1'b0; end
          else m_held.push_back(imem_bus.imem_rdata);
        end else begin
          m_pv = mv; m_ptrap = mtrap; m_ptgt = mt;
        end
      end else if (m_held.size() != 0) begin
        vl = 1'b1; ins = m_held[0];
        if (rd) begin st = 1'b0; nxt = tgt; m_held.delete(); end
        else if (!StallD) begin st = 1'b0; nxt = align(PC + 32'd4); m_held.delete(); end
      end else begin
        rq = 1'b1;
        if (rd) begin st = 1'b0; nxt = tgt; end
        else if (imem_bus.imem_gnt) m_out = 1'b1;
      end
    end
    exp_next  = nxt;
    exp_stall = st;
    chk("m_pc_next", PC_Next, nxt);
    chk("m_stallf", 32'(StallF), 32'(st));
    chk("m_validf", 32'(InstrValidF), 32'(vl));
    chk("m_instrf", InstrF, ins);
    chk("m_flushd", 32'(FlushD), 32'(fl));
    chk("m_req", 32'(imem_bus.imem_req), 32'(rq));
    chk("m_align", 32'(PC_Next[1:0]), 32'd0);
    if (rq) chk("m_addr", imem_bus.imem_addr, PC);
  end

  task automatic idle();
    StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; TrapReq = 1'b0; TrapVector = '0;
    imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;
  endtask

  task automatic nxt_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int rv_cnt;
    idle();
    rst = 1'b0;
    nxt_cyc(); nxt_cyc();

    // Boot, first fetch at the reset vector, single-cycle valid then advance.
    rst = 1'b1; #3;
    chk("boot_stallf", 32'(StallF), 32'd1);
    chk("boot_req", 32'(imem_bus.imem_req), 32'd0);
    chk("boot_valid", 32'(InstrValidF), 32'd0);
    nxt_cyc(); imem_bus.imem_gnt = 1'b1; #3;
    chk("a_req", 32'(imem_bus.imem_req), 32'd1);
    chk("a_addr", imem_bus.imem_addr, 32'h0);
    chk("a_stallf", 32'(StallF), 32'd1);
    nxt_cyc(); imem_bus.imem_gnt = 1'b0; #3;
    chk("a_wait_req", 32'(imem_bus.imem_req), 32'd0);
    nxt_cyc(); imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h0050_0093; #3;
    chk("a_wait_valid", 32'(InstrValidF), 32'd0);
    nxt_cyc(); imem_bus.imem_rvalid = 1'b0; #3;
    chk("a_instr", InstrF, 32'h0050_0093);
    chk("a_valid", 32'(InstrValidF), 32'd1);
    chk("a_pc_next", PC_Next, 32'h4);
    chk("a_stallf_adv", 32'(StallF), 32'd0);

    // Decode back-pressure for three cycles.
    nxt_cyc(); imem_bus.imem_gnt = 1'b1; #3;
    chk("b_valid_drop", 32'(InstrValidF), 32'd0);
    chk("b_instr_nop", InstrF, NOP);
    chk("b_addr", imem_bus.imem_addr, 32'h4);
    nxt_cyc(); imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'h00a0_0113; #3;
    for (int i = 0; i < 3; i++) begin
      nxt_cyc(); imem_bus.imem_rvalid = 1'b0; StallD = 1'b1; #3;
      chk("b_hold_valid", 32'(InstrValidF), 32'd1);
      chk("b_hold_instr", InstrF, 32'h00a0_0113);
      chk("b_hold_stallf", 32'(StallF), 32'd1);
      chk("b_hold_pc_next", PC_Next, 32'h4);
    end
    nxt_cyc(); StallD = 1'b0; #3;
    chk("b_adv_pc_next", PC_Next, 32'h8);
    chk("b_adv_stallf", 32'(StallF), 32'd0);

    // Branch while waiting: response discarded, refetch from the target.
    nxt_cyc(); imem_bus.imem_gnt = 1'b1; #3;
    chk("c_addr", imem_bus.imem_addr, 32'h8);
    nxt_cyc(); imem_bus.imem_gnt = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h100; #3;
    chk("c_flush", 32'(FlushD), 32'd1);
    chk("c_stallf", 32'(StallF), 32'd1);
    nxt_cyc(); PCSrcE = 1'b0; #3;
    chk("c_flush_once", 32'(FlushD), 32'd0);
    nxt_cyc(); imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hbad0_0013; #3;
    chk("c_pc_next", PC_Next, 32'h100);
    chk("c_stallf_go", 32'(StallF), 32'd0);
    chk("c_no_valid", 32'(InstrValidF), 32'd0);
    nxt_cyc(); imem_bus.imem_rvalid = 1'b0; imem_bus.imem_gnt = 1'b1; #3;
    chk("c_refetch", imem_bus.imem_addr, 32'h100);
    chk("c_refetch_req", 32'(imem_bus.imem_req), 32'd1);

    // Trap beats a simultaneous branch and a later branch.
    nxt_cyc(); imem_bus.imem_gnt = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h100;
    TrapReq = 1'b1; TrapVector = 32'h80; #3;
    chk("d_flush", 32'(FlushD), 32'd1);
    nxt_cyc(); TrapReq = 1'b0; PCTargetE = 32'h200; #3;
    chk("d_flush2", 32'(FlushD), 32'd1);
    nxt_cyc(); PCSrcE = 1'b0; imem_bus.imem_rvalid = 1'b1; #3;
    chk("d_pc_next", PC_Next, 32'h80);
    chk("d_stallf", 32'(StallF), 32'd0);
    nxt_cyc(); imem_bus.imem_rvalid = 1'b0; #3;
    chk("d_addr", imem_bus.imem_addr, 32'h80);

    // Grant withheld: request held, fetch stalled.
    for (int i = 0; i < 5; i++) begin
      nxt_cyc(); #3;
      chk("e_req", 32'(imem_bus.imem_req), 32'd1);
      chk("e_stallf", 32'(StallF), 32'd1);
      chk("e_valid", 32'(InstrValidF), 32'd0);
    end
    nxt_cyc(); imem_bus.imem_gnt = 1'b1; #3;

    // Reset while waiting, then a stray response.
    nxt_cyc(); imem_bus.imem_gnt = 1'b0; rst = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h300; #3;
    chk("f_stallf", 32'(StallF), 32'd1);
    chk("f_req", 32'(imem_bus.imem_req), 32'd0);
    chk("f_valid", 32'(InstrValidF), 32'd0);
    chk("f_flush", 32'(FlushD), 32'd0);
    nxt_cyc(); rst = 1'b1; PCSrcE = 1'b0; imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'hdead_beef; #3;
    chk("f_stray_valid", 32'(InstrValidF), 32'd0);
    chk("f_stray_req", 32'(imem_bus.imem_req), 32'd0);
    nxt_cyc(); imem_bus.imem_rvalid = 1'b0; imem_bus.imem_gnt = 1'b1; #3;
    chk("f_restart_addr", imem_bus.imem_addr, 32'h0);
    chk("f_restart_req", 32'(imem_bus.imem_req), 32'd1);
    nxt_cyc(); imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'h00c0_0193; #3;
    nxt_cyc(); imem_bus.imem_rvalid = 1'b0; #3;
    chk("f_instr", InstrF, 32'h00c0_0193);
    chk("f_pc_next", PC_Next, 32'h4);

    // Randomized traffic; the model-driven memory always answers within 4 cycles.
    rv_cnt = -1;
    for (int c = 0; c < 4000; c++) begin
      nxt_cyc();
      idle();
      rst        = ($urandom_range(0, 499) != 0);
      TrapReq    = ($urandom_range(0, 15) == 0);
      PCSrcE     = ($urandom_range(0, 9) == 0);
      TrapVector = $urandom;
      PCTargetE  = $urandom;
      StallD     = ($urandom_range(0, 2) == 0);
      if (!m_boot && !m_out && m_held.size() == 0)
        imem_bus.imem_gnt = !(TrapReq || PCSrcE) && ($urandom_range(0, 2) != 0);
      if (m_out && rst) begin
        if (rv_cnt < 0) rv_cnt = int'($urandom_range(0, 3));
        if (rv_cnt == 0) begin
          imem_bus.imem_rvalid = 1'b1;
          imem_bus.imem_rdata  = $urandom;
          rv_cnt = -1;
        end else begin
          rv_cnt--;
        end
      end else begin
        rv_cnt = -1;
      end
    end

    nxt_cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
